// File: rtl/ctrl_fsm_if.sv
// Control-unit bundle: instruction/FIFO status into ctrl_fsm, datapath strobes out.
// The step line exists only when CTRL_STEP_EN is defined.
interface ctrl_fsm_if;
   logic [7:0] instr;
   logic       inbox_empty;
   logic       outbox_full;
`ifdef CTRL_STEP_EN
   logic       step;
`endif
   logic       wIR;
   logic       wOP;
   logic       wPC;
   logic       branch;
   logic       ijump;
   logic       flag_sel;
   logic [2:0] alu_op;
   logic       wR;
   logic       wM;
   logic       rd_inbox;
   logic       wr_outbox;
   logic       halted;
   logic       illegal;
   logic [2:0] state;

   // Handshake rules:
   //   rd_inbox is a single-cycle pop, issued only while inbox_empty is low.
   //   wr_outbox is a single-cycle push, issued only while outbox_full is low.
   //   A pop or push completes in the same cycle the strobe is high.
   //   Holding inbox_empty/outbox_full high stalls the controller indefinitely.
   modport master (
`ifdef CTRL_STEP_EN
      input  step,
`endif
      input  instr, inbox_empty, outbox_full,
      output wIR, wOP, wPC, branch, ijump, flag_sel, alu_op,
      output wR, wM, rd_inbox, wr_outbox, halted, illegal, state
   );

   modport slave (
`ifdef CTRL_STEP_EN
      output step,
`endif
      output instr, inbox_empty, outbox_full,
      input  wIR, wOP, wPC, branch, ijump, flag_sel, alu_op,
      input  wR, wM, rd_inbox, wr_outbox, halted, illegal, state
   );
endinterface

// File: rtl/ctrl_fsm.sv
// Multi-cycle fetch/decode/execute sequencer of the HRM CPU.
// Optional single-step gating of FETCH is enabled by defining CTRL_STEP_EN.
module ctrl_fsm #(
   parameter int unsigned MEM_WAIT = 0
) (
   input  logic        clk,
   input  logic        rst,
   ctrl_fsm_if.master  bus
);
   typedef enum logic [2:0] {
      FETCH    = 3'd0,
      DECODE   = 3'd1,
      FETCH_OP = 3'd2,
      EXEC     = 3'd3,
      WAIT_IN  = 3'd4,
      WAIT_OUT = 3'd5,
      HALTED   = 3'd6
   } state_t;

   localparam logic [3:0] WAIT_CYC = 4'(MEM_WAIT);

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       illegal_q, illegal_nxt;
   logic [3:0] opcode;
   logic [3:0] instr_unused;
   logic       has_operand;
   logic       wait_done;
   logic       go;

   assign {opcode, instr_unused} = bus.instr;
   assign has_operand = (opcode >= 4'h2) && (opcode <= 4'hA);
   assign wait_done   = (cnt == WAIT_CYC);

`ifdef CTRL_STEP_EN
   // A step pulse arms FETCH until its memory wait completes, so one pulse runs one instruction.
   logic step_arm, step_arm_nxt;
   assign go = bus.step | step_arm;
`else
   assign go = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= FETCH;
         cnt       <= 4'd0;
         illegal_q <= 1'b0;
`ifdef CTRL_STEP_EN
         step_arm  <= 1'b0;
`endif
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         illegal_q <= illegal_nxt;
`ifdef CTRL_STEP_EN
         step_arm  <= step_arm_nxt;
`endif
      end
   end

   assign bus.illegal = illegal_q;
   assign bus.state   = state;

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      illegal_nxt   = illegal_q;
`ifdef CTRL_STEP_EN
      step_arm_nxt  = step_arm;
`endif
      bus.wIR       = 1'b0;
      bus.wOP       = 1'b0;
      bus.wPC       = 1'b0;
      bus.branch    = 1'b0;
      bus.ijump     = 1'b0;
      bus.flag_sel  = 1'b0;
      bus.alu_op    = 3'd0;
      bus.wR        = 1'b0;
      bus.wM        = 1'b0;
      bus.rd_inbox  = 1'b0;
      bus.wr_outbox = 1'b0;
      bus.halted    = 1'b0;

      // Reset wins over everything, including the Mealy FIFO strobes.
      if (!rst) begin
         case (state)
            FETCH: begin
               if (go) begin
                  if (wait_done) begin
                     bus.wIR   = 1'b1;
                     bus.wPC   = 1'b1;
                     state_nxt = DECODE;
                  end else begin
                     cnt_nxt   = cnt + 4'd1;
                  end
`ifdef CTRL_STEP_EN
                  step_arm_nxt = !wait_done;
`endif
               end
            end
            DECODE: begin
               if (has_operand)                          state_nxt = FETCH_OP;
               else if (opcode == 4'h0 || opcode == 4'h1) state_nxt = EXEC;
               else if (opcode == 4'hF)                  state_nxt = HALTED;
               else begin
                  illegal_nxt = 1'b1;
                  state_nxt   = HALTED;
               end
            end
            FETCH_OP: begin
               if (wait_done) begin
                  bus.wOP   = 1'b1;
                  bus.wPC   = (opcode <= 4'h7);
                  state_nxt = EXEC;
               end else begin
                  cnt_nxt   = cnt + 4'd1;
               end
            end
            EXEC, WAIT_IN, WAIT_OUT: begin
               state_nxt = FETCH;
               case (opcode)
                  4'h0: begin
                     if (bus.inbox_empty) state_nxt = WAIT_IN;
                     else begin
                        bus.rd_inbox = 1'b1;
                        bus.wR       = 1'b1;
                     end
                  end
                  4'h1: begin
                     if (bus.outbox_full) state_nxt = WAIT_OUT;
                     else bus.wr_outbox = 1'b1;
                  end
                  4'h2: begin bus.wR = 1'b1; bus.alu_op = 3'd1; end
                  4'h3: bus.wM = 1'b1;
                  4'h4: begin bus.wR = 1'b1; bus.alu_op = 3'd2; end
                  4'h5: begin bus.wR = 1'b1; bus.alu_op = 3'd3; end
                  4'h6: begin bus.wR = 1'b1; bus.wM = 1'b1; bus.alu_op = 3'd4; end
                  4'h7: begin bus.wR = 1'b1; bus.wM = 1'b1; bus.alu_op = 3'd5; end
                  4'h8: begin bus.wPC = 1'b1; bus.branch = 1'b1; bus.ijump = 1'b1; end
                  4'h9: begin bus.wPC = 1'b1; bus.branch = 1'b1; end
                  4'hA: begin bus.wPC = 1'b1; bus.branch = 1'b1; bus.flag_sel = 1'b1; end
                  default: ;
               endcase
            end
            HALTED: bus.halted = 1'b1;
            default: state_nxt = FETCH;
         endcase
      end

      if (state_nxt != state) cnt_nxt = 4'd0;
   end
endmodule

// File: tb/tb_ctrl_fsm.sv
// Directed bench for ctrl_fsm: per-cycle expected strobe vectors go through a scoreboard queue.
// Two instances cover MEM_WAIT=0 and MEM_WAIT=2 from shared stimulus.
module tb_ctrl_fsm;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] instr = 8'h00;
  logic       inbox_empty = 1'b1;
  logic       outbox_full = 1'b0;

  always #5 clk = ~clk;

  ctrl_fsm_if bus0();
  ctrl_fsm_if bus2();

  assign bus0.instr = instr;
  assign bus0.inbox_empty = inbox_empty;
  assign bus0.outbox_full = outbox_full;
  assign bus2.instr = instr;
  assign bus2.inbox_empty = inbox_empty;
  assign bus2.outbox_full = outbox_full;
`ifdef CTRL_STEP_EN
  assign bus0.step = 1'b1;
  assign bus2.step = 1'b1;
`endif

  ctrl_fsm #(.MEM_WAIT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  ctrl_fsm #(.MEM_WAIT(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // Vector layout: wIR wOP wPC branch ijump flag_sel alu_op[2:0] wR wM rd_inbox wr_outbox halted illegal
  localparam logic [14:0] IR = 15'h4000, OP = 15'h2000, PC = 15'h1000, BR = 15'h0800;
  localparam logic [14:0] IJ = 15'h0400, FS = 15'h0200, WR = 15'h0020, WM = 15'h0010;
  localparam logic [14:0] RI = 15'h0008, WO = 15'h0004, HA = 15'h0002, IL = 15'h0001;
  localparam logic [14:0] NONE = 15'h0000;
  localparam logic [2:0] S_FETCH = 3'd0, S_WAIT_OUT = 3'd5;

  logic [14:0] obs0, obs2;
  assign obs0 = {bus0.wIR, bus0.wOP, bus0.wPC, bus0.branch, bus0.ijump, bus0.flag_sel, bus0.alu_op,
                 bus0.wR, bus0.wM, bus0.rd_inbox, bus0.wr_outbox, bus0.halted, bus0.illegal};
  assign obs2 = {bus2.wIR, bus2.wOP, bus2.wPC, bus2.branch, bus2.ijump, bus2.flag_sel, bus2.alu_op,
                 bus2.wR, bus2.wM, bus2.rd_inbox, bus2.wr_outbox, bus2.halted, bus2.illegal};

  int total = 0;
  int bad = 0;
  logic [14:0] exp_q[$];

  function automatic logic [14:0] alu(input logic [2:0] op);
    return {6'b0, op, 6'b0};
  endfunction

  // Push the expected vector for the current cycle, compare at the falling edge, advance one cycle.
  task automatic expect_cyc(input logic [14:0] e, input bit sel2, input string tag);
    logic [14:0] got, want;
    exp_q.push_back(e);
    @(negedge clk);
    got  = sel2 ? obs2 : obs0;
    want = exp_q.pop_front();
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input logic [2:0] e, input bit sel2, input string tag);
    logic [2:0] got;
    got = sel2 ? bus2.state : bus0.state;
    total++;
    assert (got === e) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, e);
    end
  endtask

  // Leaves the bench at cycle 1 (first FETCH cycle) with rst low.
  task automatic do_reset();
    rst = 1'b1;
    inbox_empty = 1'b1;
    outbox_full = 1'b0;
    @(posedge clk);
    #1;
    check_state(S_FETCH, 1'b0, "rst_state0");
    check_state(S_FETCH, 1'b1, "rst_state2");
    expect_cyc(NONE, 1'b0, "rst_outputs");
    rst = 1'b0;
  endtask

  initial begin
    // JUMP: wIR/wPC at c1, wOP at c3, unconditional jump at c4
    instr = 8'h80;
    do_reset();
    expect_cyc(IR | PC, 0, "jump_c1_fetch");
    expect_cyc(NONE, 0, "jump_c2_decode");
    expect_cyc(OP, 0, "jump_c3_wop_no_wpc");
    expect_cyc(PC | BR | IJ, 0, "jump_c4_exec");
    expect_cyc(IR | PC, 0, "jump_c5_next_fetch");

    // JUMPZ / JUMPN: conditional branch, flag_sel picks the flag
    instr = 8'h90;
    do_reset();
    expect_cyc(IR | PC, 0, "jumpz_fetch");
    expect_cyc(NONE, 0, "jumpz_decode");
    expect_cyc(OP, 0, "jumpz_fetch_op");
    expect_cyc(PC | BR, 0, "jumpz_exec");
    instr = 8'hA0;
    expect_cyc(IR | PC, 0, "jumpn_fetch");
    expect_cyc(NONE, 0, "jumpn_decode");
    expect_cyc(OP, 0, "jumpn_fetch_op");
    expect_cyc(PC | BR | FS, 0, "jumpn_exec");

    // COPYFROM, COPYTO, ADD, SUB back to back
    instr = 8'h20;
    expect_cyc(IR | PC, 0, "copyfrom_fetch");
    expect_cyc(NONE, 0, "copyfrom_decode");
    expect_cyc(OP | PC, 0, "copyfrom_fetch_op");
    expect_cyc(WR | alu(3'd1), 0, "copyfrom_exec");
    instr = 8'h31;
    expect_cyc(IR | PC, 0, "copyto_fetch");
    expect_cyc(NONE, 0, "copyto_decode");
    expect_cyc(OP | PC, 0, "copyto_fetch_op");
    expect_cyc(WM, 0, "copyto_exec");
    instr = 8'h45;
    expect_cyc(IR | PC, 0, "add_fetch");
    expect_cyc(NONE, 0, "add_decode");
    expect_cyc(OP | PC, 0, "add_fetch_op");
    expect_cyc(WR | alu(3'd2), 0, "add_exec");
    instr = 8'h5F;
    expect_cyc(IR | PC, 0, "sub_fetch");
    expect_cyc(NONE, 0, "sub_decode");
    expect_cyc(OP | PC, 0, "sub_fetch_op");
    expect_cyc(WR | alu(3'd3), 0, "sub_exec");
    instr = 8'h70;
    expect_cyc(IR | PC, 0, "bumpdn_fetch");
    expect_cyc(NONE, 0, "bumpdn_decode");
    expect_cyc(OP | PC, 0, "bumpdn_fetch_op");
    expect_cyc(WR | WM | alu(3'd5), 0, "bumpdn_exec");

    // INBOX: five empty cycles, then a single pop; then a zero-wait pop
    instr = 8'h00;
    do_reset();
    expect_cyc(IR | PC, 0, "inbox_fetch");
    expect_cyc(NONE, 0, "inbox_decode");
    for (int i = 0; i < 5; i++) expect_cyc(NONE, 0, "inbox_empty_wait");
    inbox_empty = 1'b0;
    expect_cyc(RI | WR, 0, "inbox_pop");
    inbox_empty = 1'b1;
    expect_cyc(IR | PC, 0, "inbox_next_fetch");
    expect_cyc(NONE, 0, "inbox2_decode");
    inbox_empty = 1'b0;
    expect_cyc(RI | WR, 0, "inbox_zero_wait_pop");
    inbox_empty = 1'b1;

    // OUTBOX with space: push in EXEC
    instr = 8'h10;
    expect_cyc(IR | PC, 0, "outbox_fetch");
    expect_cyc(NONE, 0, "outbox_decode");
    expect_cyc(WO, 0, "outbox_push");

    // BUMPUP with MEM_WAIT=2
    instr = 8'h60;
    do_reset();
    expect_cyc(NONE, 1, "bumpup_w_c1");
    expect_cyc(NONE, 1, "bumpup_w_c2");
    expect_cyc(IR | PC, 1, "bumpup_w_c3_wir");
    expect_cyc(NONE, 1, "bumpup_w_decode");
    expect_cyc(NONE, 1, "bumpup_w_op1");
    expect_cyc(NONE, 1, "bumpup_w_op2");
    expect_cyc(OP | PC, 1, "bumpup_w_wop");
    expect_cyc(WR | WM | alu(3'd4), 1, "bumpup_w_exec");
    expect_cyc(NONE, 1, "bumpup_w_refetch_wait");

    // Illegal opcode: sticky illegal, absorbing halt, reset clears
    instr = 8'hC0;
    do_reset();
    expect_cyc(IR | PC, 0, "illegal_fetch");
    expect_cyc(NONE, 0, "illegal_decode");
    for (int i = 0; i < 20; i++) expect_cyc(HA | IL, 0, "illegal_halt_hold");
    instr = 8'h80;
    do_reset();
    expect_cyc(IR | PC, 0, "illegal_cleared_fetch");

    // HALT opcode: halted without illegal
    instr = 8'hF0;
    do_reset();
    expect_cyc(IR | PC, 0, "halt_fetch");
    expect_cyc(NONE, 0, "halt_decode");
    expect_cyc(HA, 0, "halt_state");
    expect_cyc(HA, 0, "halt_absorb");

    // Reset during WAIT_OUT: no push even once outbox_full drops
    instr = 8'h10;
    do_reset();
    outbox_full = 1'b1;
    expect_cyc(IR | PC, 0, "waitout_fetch");
    expect_cyc(NONE, 0, "waitout_decode");
    expect_cyc(NONE, 0, "waitout_exec_full");
    check_state(S_WAIT_OUT, 0, "waitout_state");
    expect_cyc(NONE, 0, "waitout_hold");
    rst = 1'b1;
    outbox_full = 1'b0;
    expect_cyc(NONE, 0, "waitout_rst_no_push");
    check_state(S_FETCH, 0, "waitout_rst_fetch");
    expect_cyc(NONE, 0, "waitout_rst_outputs");
    rst = 1'b0;
    expect_cyc(IR | PC, 0, "waitout_after_rst_fetch");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
